// File: rtl/mine_placer_ctrl.sv
// Mine placement sequencer: pulls candidate cells from the RNG, rejects bad ones,
// and builds the board's mine map until the requested count is reached or tries run out.
module mine_placer_ctrl #(
  parameter int CELLS     = 25,
  parameter int IDX_W     = 5,
  parameter int MAX_TRIES = 255
) (
  input  logic             in_clka,
  input  logic             in_reset_n,
  input  logic             in_start,
  input  logic [IDX_W-1:0] in_mines_num,
  input  logic [IDX_W-1:0] in_safe_index,
  input  logic             in_rng_valid,
  input  logic [IDX_W-1:0] in_rng_index,
  output logic             out_rng_req,
  output logic [CELLS-1:0] out_mines,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_error,
  output logic [1:0]       out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EVAL = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] CELLS_L     = (IDX_W+1)'(CELLS);
  localparam logic [7:0]     MAX_TRIES_L = 8'(MAX_TRIES);

  state_t           state, state_nx;
  logic [IDX_W-1:0] target, target_nx;
  logic [IDX_W-1:0] safe, safe_nx;
  logic [IDX_W-1:0] cand, cand_nx;
  logic [IDX_W-1:0] placed, placed_nx;
  logic [7:0]       tries, tries_nx;
  logic [CELLS-1:0] mines_nx;
  logic             error_nx;
  logic [CELLS-1:0] cand_bit;
  logic             cand_ok;

  // Out-of-range candidates shift the one-hot off the top, so cand_bit is zero for them.
  assign cand_bit = CELLS'(1) << cand;
  assign cand_ok  = ({1'b0, cand} < CELLS_L) && (cand != safe) && ((out_mines & cand_bit) == '0);

  // Handshake: a candidate transfers on a rising edge where out_rng_req and in_rng_valid
  // are both 1; in_rng_valid has no meaning while out_rng_req is 0.
  assign out_rng_req = (state == REQ);
  assign out_busy    = (state != IDLE);
  assign out_done    = (state == FIN);
  assign out_state   = state;

  always_comb begin
    state_nx  = state;
    target_nx = target;
    safe_nx   = safe;
    cand_nx   = cand;
    placed_nx = placed;
    tries_nx  = tries;
    mines_nx  = out_mines;
    error_nx  = out_error;
    case (state)
      IDLE: begin
        if (in_start) begin
          target_nx = in_mines_num;
          safe_nx   = in_safe_index;
          mines_nx  = '0;
          error_nx  = 1'b0;
          placed_nx = '0;
          tries_nx  = '0;
          if (in_mines_num == '0) begin
            state_nx = FIN;
          end else if ({1'b0, in_mines_num} >= CELLS_L) begin
            state_nx = FIN;
            error_nx = 1'b1;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (in_rng_valid) begin
          cand_nx  = in_rng_index;
          state_nx = EVAL;
        end
      end
      EVAL: begin
        tries_nx = tries + 8'd1;
        if (cand_ok) begin
          mines_nx  = out_mines | cand_bit;
          placed_nx = placed + IDX_W'(1);
        end
        // Reaching the target wins over running out of tries on the same evaluation.
        if (placed_nx == target) begin
          state_nx = FIN;
        end else if (tries_nx == MAX_TRIES_L) begin
          state_nx = FIN;
          error_nx = 1'b1;
        end else begin
          state_nx = REQ;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (!in_reset_n) begin
      state     <= IDLE;
      target    <= '0;
      safe      <= '0;
      cand      <= '0;
      placed    <= '0;
      tries     <= '0;
      out_mines <= '0;
      out_error <= 1'b0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      safe      <= safe_nx;
      cand      <= cand_nx;
      placed    <= placed_nx;
      tries     <= tries_nx;
      out_mines <= mines_nx;
      out_error <= error_nx;
    end
  end

endmodule

// File: tb/tb_mine_placer_ctrl.sv
// Bench for mine_placer_ctrl: directed scenarios with literal expectations plus randomized
// operations, all checked every cycle against a list-based placement model.
module tb_mine_placer_ctrl;

  localparam int CELLS     = 25;
  localparam int IDX_W     = 5;
  localparam int MAX_TRIES = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n       = 1'b0;
  logic             start       = 1'b1;
  logic [IDX_W-1:0] mines_num   = 5'd3;
  logic [IDX_W-1:0] safe_index  = 5'd0;
  logic             rng_valid   = 1'b0;
  logic [IDX_W-1:0] rng_index   = 5'd0;
  logic             out_rng_req;
  logic [CELLS-1:0] out_mines;
  logic             out_busy;
  logic             out_done;
  logic             out_error;
  logic [1:0]       out_state;

  mine_placer_ctrl #(
    .CELLS(CELLS), .IDX_W(IDX_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .in_clka      (clk),
    .in_reset_n   (rst_n),
    .in_start     (start),
    .in_mines_num (mines_num),
    .in_safe_index(safe_index),
    .in_rng_valid (rng_valid),
    .in_rng_index (rng_index),
    .out_rng_req  (out_rng_req),
    .out_mines    (out_mines),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_error    (out_error),
    .out_state    (out_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: no completion within cycle budget at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the accepted cells as a list; the map is derived from it.
  localparam int P_IDLE = 0, P_WAIT = 1, P_JUDGE = 2, P_DONE = 3;
  int  m_phase  = P_IDLE;
  int  m_target = 0;
  int  m_safe   = 0;
  int  m_cand   = 0;
  int  m_tries  = 0;
  bit  m_err    = 1'b0;
  bit  m_known  = 1'b0;
  int  acc_q[$];

  function automatic bit already_mined(input int c);
    foreach (acc_q[i]) if (acc_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CELLS-1:0] map_of();
    logic [CELLS-1:0] m = '0;
    foreach (acc_q[i]) m[acc_q[i]] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      acc_q.delete();
      m_err   = 1'b0;
      m_tries = 0;
      m_known = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_target = int'(mines_num);
          m_safe   = int'(safe_index);
          acc_q.delete();
          m_err    = 1'b0;
          m_tries  = 0;
          if (m_target == 0) m_phase = P_DONE;
          else if (m_target >= CELLS) begin m_phase = P_DONE; m_err = 1'b1; end
          else m_phase = P_WAIT;
        end
        P_WAIT: if (rng_valid) begin
          m_cand  = int'(rng_index);
          m_phase = P_JUDGE;
        end
        P_JUDGE: begin
          m_tries++;
          if (m_cand < CELLS && m_cand != m_safe && !already_mined(m_cand)) acc_q.push_back(m_cand);
          if (acc_q.size() == m_target) m_phase = P_DONE;
          else if (m_tries == MAX_TRIES) begin m_phase = P_DONE; m_err = 1'b1; end
          else m_phase = P_WAIT;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      check("req",   32'(out_rng_req), 32'(m_phase == P_WAIT));
      check("busy",  32'(out_busy),    32'(m_phase != P_IDLE));
      check("done",  32'(out_done),    32'(m_phase == P_DONE));
      check("mines", 32'(out_mines),   32'(map_of()));
      check("error", 32'(out_error),   32'(m_err));
    end
  end

  // ---------------- rng driver ----------------
  // Mode 0: random valid/index; 1: always valid, indices from rng_q; 2: stuck at stuck_idx.
  int rng_mode   = 0;
  int stuck_idx  = 0;
  int rng_q[$];
  bit hs_pending = 1'b0;

  always @(negedge clk) begin
    if (hs_pending && rng_q.size() > 0) void'(rng_q.pop_front());
    case (rng_mode)
      1: begin
        rng_valid = 1'b1;
        if (rng_q.size() > 0) rng_index = IDX_W'(rng_q[0]);
        else rng_index = IDX_W'($urandom_range(0, 31));
      end
      2: begin
        rng_valid = 1'b1;
        rng_index = IDX_W'(stuck_idx);
      end
      default: begin
        rng_valid = ($urandom_range(0, 3) != 0);
        rng_index = IDX_W'($urandom_range(0, 31));
      end
    endcase
    hs_pending = out_rng_req && rng_valid;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; the following edge is "edge 0" that samples start.
  task automatic do_start(input int n, input int s);
    start      = 1'b1;
    mines_num  = IDX_W'(n);
    safe_index = IDX_W'(s);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int c0, input int budget,
                           output int cyc, output bit saw_req);
    cyc = -1;
    saw_req = 1'b0;
    for (int c = c0; c < c0 + budget; c++) begin
      @(negedge clk);
      if (out_rng_req) saw_req = 1'b1;
      if (out_done) begin cyc = c; break; end
    end
    if (cyc < 0) timeout_fail(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit saw_req;
    int done_seen;
    bit fin;
    int r;
    int n;

    // Reset held two cycles with start asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mines", 32'(out_mines), 32'd0);
    check("rst_busy",  32'(out_busy),  32'd0);
    check("rst_done",  32'(out_done),  32'd0);
    check("rst_req",   32'(out_rng_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;

    // Rejections: duplicate, safe cell, out of range.
    rng_mode = 1;
    rng_q = '{4, 4, 12, 30, 7, 20};
    do_start(3, 12);
    wait_done("t2_done", 1, 40, cyc, saw_req);
    check("t2_cycle", 32'(cyc), 32'd13);
    check("t2_mines", 32'(out_mines), 32'h0100090);
    check("t2_error", 32'(out_error), 32'd0);
    @(posedge clk); #1;

    // Zero mines.
    rng_mode = 0;
    do_start(0, 5);
    wait_done("t3_done", 1, 10, cyc, saw_req);
    check("t3_cycle", 32'(cyc), 32'd1);
    check("t3_noreq", 32'(saw_req), 32'd0);
    check("t3_mines", 32'(out_mines), 32'd0);
    @(posedge clk); #1;

    // Illegal count, error sticky in idle.
    do_start(25, 3);
    wait_done("t4_done", 1, 10, cyc, saw_req);
    check("t4_cycle", 32'(cyc), 32'd1);
    check("t4_error", 32'(out_error), 32'd1);
    check("t4_mines", 32'(out_mines), 32'd0);
    check("t4_noreq", 32'(saw_req), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_sticky", 32'(out_error), 32'd1);
    @(posedge clk); #1;

    // Tries exhausted with rng stuck on one cell.
    rng_mode  = 2;
    stuck_idx = 3;
    do_start(2, 12);
    wait_done("t5_done", 1, 60, cyc, saw_req);
    check("t5_cycle", 32'(cyc), 32'd17);
    check("t5_mines", 32'(out_mines), 32'h0000008);
    check("t5_error", 32'(out_error), 32'd1);
    @(posedge clk); #1;

    // Reset after the first accept.
    rng_mode = 1;
    rng_q = '{6, 6, 8, 10};
    do_start(3, 0);
    done_seen = 0;
    fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (out_done) done_seen++;
      if (out_mines != '0) fin = 1'b1;
    end
    if (!fin) timeout_fail("t6_first_accept");
    check("t6_first", 32'(out_mines), 32'h0000040);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rng_q.delete();
    @(negedge clk);
    check("t6_rst_mines", 32'(out_mines), 32'd0);
    check("t6_rst_busy",  32'(out_busy),  32'd0);
    repeat (3) begin
      @(negedge clk);
      if (out_done) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    @(posedge clk); #1;

    // Start pulse while busy must not disturb target/safe.
    rng_q = '{9, 2, 1, 3, 5};
    do_start(4, 2);
    start      = 1'b1;
    mines_num  = 5'd1;
    safe_index = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6b_done", 2, 40, cyc, saw_req);
    check("t6b_cycle", 32'(cyc), 32'd11);
    check("t6b_mines", 32'(out_mines), 32'h000022A);
    check("t6b_error", 32'(out_error), 32'd0);
    @(posedge clk); #1;

    // Randomized operations with busy-start pulses and occasional mid-run reset.
    rng_mode = 0;
    for (int op = 0; op < 60; op++) begin
      r = $urandom_range(0, 19);
      if (r == 0) n = 0;
      else if (r == 1) n = $urandom_range(25, 31);
      else if (r < 4) n = $urandom_range(5, 24);
      else n = $urandom_range(1, 4);
      do_start(n, $urandom_range(0, 24));
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
        @(negedge clk);
        if (out_done || !out_busy) begin
          fin = 1'b1;
        end else begin
          r = $urandom_range(0, 59);
          @(posedge clk); #1;
          if (r == 0) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            fin = 1'b1;
          end else if (r < 6) begin
            start      = 1'b1;
            mines_num  = IDX_W'($urandom_range(0, 31));
            safe_index = IDX_W'($urandom_range(0, 24));
            @(posedge clk); #1;
            start = 1'b0;
          end
        end
      end
      if (!fin) timeout_fail("rand_done");
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
